// File: rtl/scm_sched_pkg.sv
// Shared types and size helpers for the SCM access scheduler.
// Default widths here also size the write-request struct used by the top.
package scm_sched_pkg;

    localparam int SCM_ADDR_WIDTH = 5;
    localparam int SCM_DATA_WIDTH = 32;

    function automatic int num_words(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int num_byte(input int data_width);
        return data_width / 8;
    endfunction

    typedef struct packed {
        logic [SCM_ADDR_WIDTH-1:0]   addr;
        logic [SCM_DATA_WIDTH-1:0]   data;
        logic [SCM_DATA_WIDTH/8-1:0] be;
    } scm_wreq_t;

endpackage

// File: rtl/scm_rr_arbiter.sv
// N-input round-robin arbiter with a global inhibit.
// The pointer moves to one past the last granted requester.
module scm_rr_arbiter #(
    parameter int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     valid,
    input  logic             inhibit,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] rr_ptr;
    int               cand;

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!gnt_any && !inhibit && valid[cand]) begin
                grant[cand] = 1'b1;
                gnt_idx     = IDX_W'(cand);
                gnt_any     = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/scm_access_scheduler.sv
// Arbitrates the single SCM write port among N_WREQ requesters and sequences
// the read ports, stalling reads that collide with the word being written.
module scm_access_scheduler
    import scm_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = SCM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SCM_DATA_WIDTH,
    parameter int N_WREQ     = 3,
    parameter int N_READ     = 2,
    parameter int STALL_MAX  = 4,
    localparam int NUM_BYTE  = num_byte(DATA_WIDTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_WREQ-1:0]            wreq_valid_i,
    output logic [N_WREQ-1:0]            wreq_ready_o,
    input  logic [N_WREQ*ADDR_WIDTH-1:0] wreq_addr_i,
    input  logic [N_WREQ*DATA_WIDTH-1:0] wreq_data_i,
    input  logic [N_WREQ*NUM_BYTE-1:0]   wreq_be_i,
    input  logic [N_READ-1:0]            rreq_valid_i,
    output logic [N_READ-1:0]            rreq_ready_o,
    input  logic [N_READ*ADDR_WIDTH-1:0] rreq_addr_i,
    output logic [N_READ-1:0]            rvalid_o,
    output logic [N_READ*DATA_WIDTH-1:0] rdata_o,
    output logic                         scm_we_o,
    output logic [ADDR_WIDTH-1:0]        scm_waddr_o,
    output logic [DATA_WIDTH-1:0]        scm_wdata_o,
    output logic [NUM_BYTE-1:0]          scm_wbe_o,
    output logic [N_READ-1:0]            scm_re_o,
    output logic [N_READ*ADDR_WIDTH-1:0] scm_raddr_o,
    input  logic [N_READ*DATA_WIDTH-1:0] scm_rdata_i
);

    localparam int IDX_W = (N_WREQ > 1) ? $clog2(N_WREQ) : 1;
    localparam int CNT_W = $clog2(STALL_MAX + 1);

    logic [N_WREQ-1:0] wgrant;
    logic [IDX_W-1:0]  widx;
    logic              wany;
    logic              guard_active;
    logic              guard_nxt;
    scm_wreq_t         wsel;
    logic [N_READ-1:0] hazard;
    logic [CNT_W-1:0]  stall_cnt [N_READ];
    logic [CNT_W-1:0]  stall_nxt [N_READ];
    logic [N_READ-1:0] rvalid_q;

    // Reset also inhibits grants so every ready output is low while rst is high.
    scm_rr_arbiter #(.N(N_WREQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   (wreq_valid_i),
        .inhibit (guard_active | rst),
        .grant   (wgrant),
        .gnt_idx (widx),
        .gnt_any (wany)
    );

    assign wreq_ready_o = wgrant;

    always_comb begin
        wsel = '0;
        if (wany) begin
            wsel.addr = wreq_addr_i[widx*ADDR_WIDTH +: ADDR_WIDTH];
            wsel.data = wreq_data_i[widx*DATA_WIDTH +: DATA_WIDTH];
            wsel.be   = wreq_be_i[widx*NUM_BYTE +: NUM_BYTE];
        end
    end

    assign scm_we_o    = wany & (|wsel.be);
    assign scm_waddr_o = wsel.addr;
    assign scm_wdata_o = wsel.data;
    assign scm_wbe_o   = wsel.be;

    // A read must not sample a word whose latches are open this cycle.
    always_comb begin
        for (int p = 0; p < N_READ; p++) begin
            hazard[p]       = scm_we_o && (rreq_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == scm_waddr_o);
            rreq_ready_o[p] = rreq_valid_i[p] & ~hazard[p] & ~rst;
        end
    end

    assign scm_re_o    = rreq_ready_o;
    assign scm_raddr_o = rreq_addr_i;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = scm_rdata_i;

    always_comb begin
        guard_nxt = 1'b0;
        for (int p = 0; p < N_READ; p++) begin
            if (guard_active || !rreq_valid_i[p] || rreq_ready_o[p]) begin
                stall_nxt[p] = '0;
            end else if (stall_cnt[p] != CNT_W'(STALL_MAX)) begin
                stall_nxt[p] = stall_cnt[p] + 1'b1;
            end else begin
                stall_nxt[p] = stall_cnt[p];
            end
            guard_nxt = guard_nxt | (stall_nxt[p] == CNT_W'(STALL_MAX));
        end
        guard_nxt = guard_nxt & ~guard_active;
    end

    // NOTE: the counter array is small state, not storage, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q     <= '0;
            guard_active <= 1'b0;
            for (int p = 0; p < N_READ; p++) stall_cnt[p] <= '0;
        end else begin
            rvalid_q     <= scm_re_o;
            guard_active <= guard_nxt;
            for (int p = 0; p < N_READ; p++) stall_cnt[p] <= stall_nxt[p];
        end
    end

endmodule

// File: tb/tb_scm_access_scheduler.sv
// Directed bench for scm_access_scheduler with a behavioural SCM model.
// Expected grants and read data are hand-derived from the stimulus below.
module tb_scm_access_scheduler;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int NW = 3;
    localparam int NR = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NW-1:0]    wreq_valid;
    logic [NW-1:0]    wreq_ready;
    logic [NW*AW-1:0] wreq_addr;
    logic [NW*DW-1:0] wreq_data;
    logic [NW*NB-1:0] wreq_be;
    logic [NR-1:0]    rreq_valid;
    logic [NR-1:0]    rreq_ready;
    logic [NR*AW-1:0] rreq_addr;
    logic [NR-1:0]    rvalid;
    logic [NR*DW-1:0] rdata;
    logic             scm_we;
    logic [AW-1:0]    scm_waddr;
    logic [DW-1:0]    scm_wdata;
    logic [NB-1:0]    scm_wbe;
    logic [NR-1:0]    scm_re;
    logic [NR*AW-1:0] scm_raddr;
    logic [NR*DW-1:0] scm_rdata;

    logic [DW-1:0] mem [32];
    logic [DW-1:0] rd  [NR];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scm_access_scheduler #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_WREQ(NW), .N_READ(NR), .STALL_MAX(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wreq_valid_i (wreq_valid),
        .wreq_ready_o (wreq_ready),
        .wreq_addr_i  (wreq_addr),
        .wreq_data_i  (wreq_data),
        .wreq_be_i    (wreq_be),
        .rreq_valid_i (rreq_valid),
        .rreq_ready_o (rreq_ready),
        .rreq_addr_i  (rreq_addr),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .scm_we_o     (scm_we),
        .scm_waddr_o  (scm_waddr),
        .scm_wdata_o  (scm_wdata),
        .scm_wbe_o    (scm_wbe),
        .scm_re_o     (scm_re),
        .scm_raddr_o  (scm_raddr),
        .scm_rdata_i  (scm_rdata)
    );

    // SCM model: initialised to 0xA5A5_00nn while in reset, samples at the rising edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA5A5_0000 | i;
        end else begin
            if (scm_we)
                for (int b = 0; b < NB; b++)
                    if (scm_wbe[b]) mem[scm_waddr][b*8 +: 8] <= scm_wdata[b*8 +: 8];
            for (int p = 0; p < NR; p++)
                if (scm_re[p]) rd[p] <= mem[scm_raddr[p*AW +: AW]];
        end
    end

    assign scm_rdata = {rd[1], rd[0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int g, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] be);
        wreq_valid[g]        = v;
        wreq_addr[g*AW +: AW] = a;
        wreq_data[g*DW +: DW] = d;
        wreq_be[g*NB +: NB]   = be;
    endtask

    task automatic set_r(input int p, input logic v, input logic [AW-1:0] a);
        rreq_valid[p]         = v;
        rreq_addr[p*AW +: AW] = a;
    endtask

    task automatic clear_all();
        wreq_valid = '0; wreq_addr = '0; wreq_data = '0; wreq_be = '0;
        rreq_valid = '0; rreq_addr = '0;
    endtask

    initial begin
        logic [NW-1:0] exp_g [4];
        exp_g[0] = 3'b100; exp_g[1] = 3'b001; exp_g[2] = 3'b010; exp_g[3] = 3'b100;

        rst = 1'b1;
        clear_all();
        for (int g = 0; g < NW; g++) set_w(g, 1'b1, AW'(g), 32'h1, 4'hF);
        set_r(0, 1'b1, 5'd1);
        set_r(1, 1'b1, 5'd2);
        repeat (3) @(posedge clk);
        #1;
        check("reset_wready", 64'(wreq_ready), 64'h0);
        check("reset_rready", 64'(rreq_ready), 64'h0);
        check("reset_rvalid", 64'(rvalid), 64'h0);
        clear_all();
        rst = 1'b0;

        // All writers valid, distinct addresses: grants 0,1,2,0,1,2.
        for (int g = 0; g < NW; g++) set_w(g, 1'b1, AW'(10 + g), 32'h1000 + g, 4'hF);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_grant", 64'(wreq_ready), 64'(3'b001 << (i % 3)));
            check("rr_we", 64'(scm_we), 64'h1);
            check("rr_waddr", 64'(scm_waddr), 64'(10 + (i % 3)));
            tick();
        end

        // Partial write to addr 5 collides with read port 0.
        clear_all();
        set_w(1, 1'b1, 5'd5, 32'hDEADBEEF, 4'b0011);
        set_r(0, 1'b1, 5'd5);
        #1;
        check("haz_wgrant", 64'(wreq_ready), 64'(3'b010));
        check("haz_rready0", 64'(rreq_ready[0]), 64'h0);
        tick();
        set_w(1, 1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        check("haz_accept", 64'(rreq_ready[0]), 64'h1);
        check("haz_no_rvalid", 64'(rvalid[0]), 64'h0);
        tick();
        set_r(0, 1'b0, 5'd0);
        #1;
        check("haz_rvalid", 64'(rvalid[0]), 64'h1);
        check("haz_rdata", 64'(rdata[31:0]), 64'hA5A5_BEEF);
        tick();

        // Zero-byte-enable transfer completes and advances the pointer (ptr=2 -> 0).
        set_w(2, 1'b1, 5'd20, 32'h55, 4'b0000);
        #1;
        check("be0_grant", 64'(wreq_ready), 64'(3'b100));
        check("be0_we", 64'(scm_we), 64'h0);
        check("idle_rvalid", 64'(rvalid), 64'h0);
        tick();
        set_w(1, 1'b1, 5'd21, 32'h66, 4'hF);
        set_w(2, 1'b1, 5'd22, 32'h77, 4'hF);
        #1;
        check("be0_next_grant", 64'(wreq_ready), 64'(3'b010));
        check("be0_next_we", 64'(scm_we), 64'h1);
        tick();

        // Writers hammer addr 7 while read port 1 waits: 4 stalls, then a guard cycle.
        clear_all();
        for (int g = 0; g < NW; g++) set_w(g, 1'b1, 5'd7, 32'h7000_0000 + g, 4'hF);
        set_r(1, 1'b1, 5'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("starve_stall", 64'(rreq_ready[1]), 64'h0);
            check("starve_grant", 64'(wreq_ready), 64'(exp_g[i]));
            tick();
        end
        #1;
        check("guard_no_grant", 64'(wreq_ready), 64'h0);
        check("guard_no_we", 64'(scm_we), 64'h0);
        check("guard_accept", 64'(rreq_ready[1]), 64'h1);
        tick();
        set_r(1, 1'b0, 5'd0);
        #1;
        check("guard_rvalid", 64'(rvalid), 64'(2'b10));
        check("guard_rdata", 64'(rdata[63:32]), 64'h7000_0002);
        check("guard_ptr_held", 64'(wreq_ready), 64'(3'b001));
        tick();

        // Both read ports on addr 3 while the write targets addr 9.
        clear_all();
        set_w(0, 1'b1, 5'd9, 32'h9999, 4'hF);
        set_r(0, 1'b1, 5'd3);
        set_r(1, 1'b1, 5'd3);
        #1;
        check("dual_rready", 64'(rreq_ready), 64'(2'b11));
        check("dual_we", 64'(scm_we), 64'h1);
        tick();
        #1;
        check("dual_rvalid", 64'(rvalid), 64'(2'b11));
        check("dual_rdata0", 64'(rdata[31:0]), 64'hA5A5_0003);
        check("dual_rdata1", 64'(rdata[63:32]), 64'hA5A5_0003);

        // Asynchronous reset mid-cycle while rvalid is high; pointer was 1 before.
        for (int g = 0; g < NW; g++) set_w(g, 1'b1, AW'(12 + g), 32'h0, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_rvalid", 64'(rvalid), 64'h0);
        check("mrst_wready", 64'(wreq_ready), 64'h0);
        check("mrst_rready", 64'(rreq_ready), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_first_grant", 64'(wreq_ready), 64'(3'b001));
        tick();
        check("mrst_second_grant", 64'(wreq_ready), 64'(3'b010));
        clear_all();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/scm_access_scheduler.md
Name: scm_access_scheduler

Overview:
- Shares the single byte-enabled write port of a latch-based standard-cell-memory register file (1W/N_READ, 2**ADDR_WIDTH words) between N_WREQ write requesters.
- Sequences the N_READ read ports with valid/ready handshakes and a one-cycle read-data valid.
- Stalls a read that would sample a word while that word's latches are being written.
- Starvation guard ensures a read port cannot be blocked indefinitely by writes.
- Sits directly in front of the SCM macro inside cluster-level register/scratch storage.

Parameters:
- ADDR_WIDTH, 5, word address width; NUM_WORDS = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width; multiple of 8; NUM_BYTE = DATA_WIDTH/8.
- N_WREQ, 3, number of write requesters.
- N_READ, 2, number of SCM read ports, one requester each.
- STALL_MAX, 4, consecutive stalled cycles before the starvation guard fires (>=1).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous active-high reset.
- wreq_valid_i  in  N_WREQ  write request valid, per requester.
- wreq_ready_o  out  N_WREQ  write grant; a transfer occurs on valid&ready.
- wreq_addr_i  in  N_WREQ*ADDR_WIDTH  write word address.
- wreq_data_i  in  N_WREQ*DATA_WIDTH  write data.
- wreq_be_i  in  N_WREQ*NUM_BYTE  write byte enables.
- rreq_valid_i  in  N_READ  read request valid.
- rreq_ready_o  out  N_READ  read accepted.
- rreq_addr_i  in  N_READ*ADDR_WIDTH  read word address.
- rvalid_o  out  N_READ  read data valid; one cycle after accept.
- rdata_o  out  N_READ*DATA_WIDTH  read data.
- scm_we_o, scm_waddr_o, scm_wdata_o, scm_wbe_o  out  1/ADDR_WIDTH/DATA_WIDTH/NUM_BYTE  SCM write port.
- scm_re_o, scm_raddr_o  out  N_READ / N_READ*ADDR_WIDTH  SCM read enables and addresses.
- scm_rdata_i  in  N_READ*DATA_WIDTH  SCM read data.

Behaviour:
- Reset (async, rst=1): rr_ptr=0; rvalid_o=0; stall counters=0; guard_active=0; all ready outputs 0 while rst is high.
- Write arbitration:
  - Round-robin starting at rr_ptr; at most one wreq_ready_o bit high per cycle.
  - ready is combinational from valid, pointer and guard; it never depends on the requester's own ready.
  - On a transfer by requester g: rr_ptr <= (g+1) mod N_WREQ. With no transfer, rr_ptr holds.
- Write issue:
  - scm_we_o = transfer & |be.
  - scm_waddr_o, scm_wdata_o and scm_wbe_o are driven combinationally from the granted requester.
  - The SCM samples these at the same rising edge.
  - A transfer with be==0 is accepted and completes: pointer advances, scm_we_o stays 0.
  - When there is no transfer, scm_we_o=0 and the other write outputs are don't-care, driven 0.
- Read hazard: hazard[p] = scm_we_o & (rreq_addr[p]==scm_waddr_o). Byte enables are ignored for this compare.
- Read handshake:
  - rreq_ready_o[p] = rreq_valid_i[p] & ~hazard[p].
  - scm_re_o[p] = rreq_ready_o[p]; scm_raddr_o[p] = rreq_addr_i[p].
  - rvalid_o[p] <= scm_re_o[p] on the next edge. rdata_o = scm_rdata_i (pass-through), valid exactly in the cycle after accept.
  - While port p is idle, the SCM holds its last address, so rdata_o stays stable but rvalid_o=0.
- Starvation guard:
  - stall_cnt[p] increments while valid & ~ready, saturating at STALL_MAX; it clears on accept or when valid drops.
  - When any stall_cnt reaches STALL_MAX, guard_active=1 for the next cycle. During that cycle all wreq_ready_o=0, so that read proceeds.
  - After that cycle guard_active=0, the counters are cleared and rr_ptr is unchanged.
- Simultaneous events: reads to different addresses than the write proceed in the same cycle; multiple read ports may share an address.
- Mid-operation reset: outstanding rvalid is discarded; requesters must re-present requests.

Decomposition:
- Package scm_sched_pkg: NUM_WORDS/NUM_BYTE derivation functions and a write-request struct typedef (addr, data, be).
- One sub-module, scm_rr_arbiter: N-input round-robin with pointer, grant vector and a global inhibit input (used for the guard).

Test Plan:
- All 3 writers valid continuously, distinct addresses, after reset -> grants ordered 0,1,2,0,1,2…; scm_we_o=1 every cycle.
- Writer 1 writes addr 5, data 0xDEADBEEF, be=4'b0011; read port 0 requests addr 5 in the same cycle -> rreq_ready_o[0]=0. Next cycle accepted; following cycle rvalid_o[0]=1 with rdata_o[15:0]=0xBEEF and the upper half unchanged.
- Writer with be=0 -> wreq_ready_o=1 and scm_we_o=0; a subsequent write from the next requester follows round-robin order.
- Writers hammer addr 7 every cycle while read port 1 requests addr 7 -> stalled exactly STALL_MAX=4 cycles, then one cycle with no write grant and the read accepted; rvalid_o[1] one cycle later.
- Both read ports request addr 3 while the write targets addr 9 -> both accepted the same cycle; both rvalid next cycle with identical data.
- rst asserted asynchronously mid-cycle while rvalid_o=1 -> rvalid_o drops immediately, all ready outputs 0; after release, the first grant goes to requester 0.
